// File: rtl/cpu_instruction_prefetch.sv
// Instruction prefetcher: issues sequential reads, tags returned words with their PC
// and writes {PC, instruction} into the downstream FIFO under a credit budget.
module cpu_instruction_prefetch #(
    parameter int                      ADDRESS_BITS    = 16,
    parameter int                      DATA_BITS       = 16,
    parameter int                      FIFO_DEPTH_BITS = 4,
    parameter int                      MAX_OUTSTANDING = 2,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC        = '0
) (
    input  logic                           CLK,
    input  logic                           RSTb,
    input  logic                           fetch_en,
    input  logic                           branch,
    input  logic [ADDRESS_BITS-1:0]        branch_pc,
    output logic [ADDRESS_BITS-1:0]        mem_addr,
    output logic                           mem_rd,
    input  logic                           mem_gnt,
    input  logic                           mem_valid,
    input  logic [DATA_BITS-1:0]           mem_data,
    output logic [ADDRESS_BITS+DATA_BITS-1:0] fifo_data,
    output logic                           fifo_wr,
    input  logic                           fifo_rd,
    output logic                           fifo_flush,
    output logic                           dbg_state
);

    // Handshake: a read is transferred in a cycle where mem_rd and mem_gnt are both high;
    // mem_rd/mem_addr hold until then except across branch or reset. mem_valid returns
    // data in grant order; fifo_wr is a one-cycle write strobe with no back-pressure.

    localparam logic [FIFO_DEPTH_BITS:0] CREDIT_MAX = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    localparam logic [1:0]               OUT_MAX    = 2'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [ADDRESS_BITS-1:0]   req_pc;
    logic [ADDRESS_BITS-1:0]   resp_pc;
    logic [FIFO_DEPTH_BITS:0]  credits;
    logic [FIFO_DEPTH_BITS:0]  credits_nxt;
    logic [1:0]                outstanding;
    logic [1:0]                out_nxt;
    logic [1:0]                drop_cnt;
    logic                      gnt_fire;
    logic                      keep;

    assign mem_addr  = req_pc;
    assign mem_rd    = (state == FETCH) && (credits != '0) && (outstanding < OUT_MAX) && !fifo_flush;
    assign gnt_fire  = mem_rd && mem_gnt;
    assign keep      = mem_valid && (drop_cnt == 2'd0);
    assign out_nxt   = outstanding + 2'(gnt_fire) - 2'(mem_valid);
    assign dbg_state = state;

    // Pops during the flush cycle belong to entries the flush discards.
    always_comb begin
        credits_nxt = credits;
        if (!fifo_flush) begin
            credits_nxt = credits + (FIFO_DEPTH_BITS+1)'(fifo_rd) - (FIFO_DEPTH_BITS+1)'(gnt_fire);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en) state_nxt = FETCH;
            FETCH:   if (!fetch_en && (!mem_rd || mem_gnt)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            credits     <= CREDIT_MAX;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            fifo_wr     <= 1'b0;
            fifo_data   <= '0;
            fifo_flush  <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            fifo_flush  <= branch;
            fifo_wr     <= keep && !branch;
            if (keep && !branch) begin
                fifo_data <= {resp_pc, mem_data};
            end
            if (branch) begin
                // Everything still in flight after this cycle belongs to the old stream.
                req_pc   <= branch_pc;
                resp_pc  <= branch_pc;
                credits  <= CREDIT_MAX;
                drop_cnt <= out_nxt;
            end else begin
                credits <= credits_nxt;
                if (gnt_fire) begin
                    req_pc <= req_pc + 1'b1;
                end
                if (keep) begin
                    resp_pc <= resp_pc + 1'b1;
                end
                if (mem_valid && (drop_cnt != 2'd0)) begin
                    drop_cnt <= drop_cnt - 2'd1;
                end
            end
        end
    end

    a_credit_bound: assert property (@(posedge CLK) disable iff (!RSTb) credits <= CREDIT_MAX);

endmodule

// File: tb/tb_cpu_instruction_prefetch.sv
// Bench for cpu_instruction_prefetch: random memory/consumer model, epoch-tagged
// scoreboard of expected FIFO writes, and a decoupled write monitor.
module tb_cpu_instruction_prefetch;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        fetch_en;
    logic        branch;
    logic [15:0] branch_pc;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_gnt;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic [31:0] fifo_data;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        fifo_flush;
    logic        dbg_state;

    cpu_instruction_prefetch dut (
        .CLK(CLK), .RSTb(RSTb), .fetch_en(fetch_en), .branch(branch), .branch_pc(branch_pc),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
        .mem_data(mem_data), .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .fifo_flush(fifo_flush), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          due;
        int          tag;
    } mem_ent_t;

    mem_ent_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_gnt = 0, wr_cnt = 0, occ = 0, epoch = 0;
    int gnt_pct = 100, pop_pct = 0, pop_budget = 0, dly_min = 1, dly_max = 1;
    int br_mode = 0, br_hit = 0, br_pct = 0;
    logic [15:0] br_target = 16'h0;
    logic [15:0] exp_req = 16'h0;
    logic        rd_prev = 0, gnt_prev = 0, br_prev = 0;
    logic [15:0] addr_prev = 0, bpc_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected {PC, data}.
    always @(negedge CLK) begin
        if (RSTb && fifo_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL fifo_wr_unexpected: got %h expected no write", fifo_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("fifo_data", fifo_data, exp_word);
            end
        end
    end

    // One cycle of memory, consumer and branch stimulus plus the reference model.
    task automatic step();
        mem_ent_t    e;
        logic        have_v;
        int          vtag;
        int          out_now;
        logic [31:0] vword;
        logic        do_br;
        @(negedge CLK);
        cyc++;
        check("fifo_flush", fifo_flush, br_prev);
        if (br_prev) begin
            check("rd_in_flush", mem_rd, 0);
            check("addr_after_branch", mem_addr, bpc_prev);
        end
        if (rd_prev && !gnt_prev && !br_prev) begin
            check("rd_hold", mem_rd, 1);
            check("addr_hold", mem_addr, addr_prev);
        end
        if (fifo_wr) check("fifo_not_full", occ < 16, 1);

        have_v    = 1'b0;
        vtag      = 0;
        vword     = '0;
        mem_valid = 1'b0;
        mem_data  = 16'($urandom);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            e         = mem_q.pop_front();
            have_v    = 1'b1;
            vtag      = e.tag;
            vword     = {e.addr, e.data};
            mem_valid = 1'b1;
            mem_data  = e.data;
        end
        out_now = mem_q.size() + int'(have_v);

        mem_gnt = mem_rd && ($urandom_range(99) < gnt_pct);
        if (mem_gnt) begin
            check("req_addr", mem_addr, exp_req);
            check("outstanding_limit", out_now < 2, 1);
            e.addr = mem_addr;
            e.data = 16'($urandom);
            e.due  = cyc + $urandom_range(dly_max, dly_min);
            e.tag  = epoch;
            mem_q.push_back(e);
            exp_req++;
            n_gnt++;
        end

        case (br_mode)
            1:       do_br = (out_now == 2);
            2:       do_br = mem_gnt && have_v;
            3:       do_br = 1'b1;
            4:       do_br = ($urandom_range(99) < br_pct);
            default: do_br = 1'b0;
        endcase
        branch = do_br;
        if (do_br) begin
            branch_pc = (br_mode == 4) ? 16'($urandom) : br_target;
            epoch++;
            exp_req = branch_pc;
            if (br_mode != 4) begin
                br_mode = 0;
                br_hit  = 1;
            end
        end
        if (have_v && vtag == epoch) exp_q.push_back(vword);

        fifo_rd = (occ > 0) && !fifo_flush && !do_br && (pop_budget > 0 || $urandom_range(99) < pop_pct);
        if (fifo_rd && pop_budget > 0) pop_budget--;
        if (fifo_flush) occ = 0;
        else occ = occ + int'(fifo_wr) - int'(fifo_rd);

        rd_prev   = mem_rd;
        gnt_prev  = mem_gnt;
        addr_prev = mem_addr;
        br_prev   = do_br;
        bpc_prev  = branch_pc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_branch(input string name);
        br_hit = 0;
        for (int i = 0; i < 200 && br_hit == 0; i++) step();
        check(name, br_hit, 1);
    endtask

    initial begin
        RSTb = 1'b0; fetch_en = 0; branch = 0; branch_pc = 0;
        mem_gnt = 0; mem_valid = 0; mem_data = 0; fifo_rd = 0;
        repeat (3) @(negedge CLK);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_fifo_flush", fifo_flush, 0);
        check("rst_state", dbg_state, 0);
        RSTb = 1'b1;

        // Fill the FIFO with no pops: 16 writes, then starved of credits.
        fetch_en = 1; gnt_pct = 100; dly_min = 2; dly_max = 2;
        run(60);
        check("fill_writes", wr_cnt, 16);
        check("fill_grants", n_gnt, 16);
        check("fill_rd_low", mem_rd, 0);
        check("fill_state", dbg_state, 1);

        // Three pops buy exactly three more reads.
        pop_budget = 3;
        run(30);
        check("pop3_grants", n_gnt, 19);
        check("pop3_writes", wr_cnt, 19);
        check("pop3_rd_low", mem_rd, 0);

        // Branch with two reads in flight.
        pop_pct = 100; dly_min = 3; dly_max = 3;
        br_target = 16'h4000; br_mode = 1;
        wait_branch("branch_out2_hit");
        run(20);

        // Branch coinciding with a grant and a response.
        dly_min = 1; dly_max = 2;
        br_target = 16'h8000; br_mode = 2;
        wait_branch("branch_gnt_valid_hit");
        run(20);

        // Address wrap.
        br_target = 16'hFFFD; br_mode = 3;
        step();
        run(40);

        // Grant stall, then fetch_en drop while a request is pending.
        run(5);
        gnt_pct = 0;
        run(5);
        check("stall_rd_high", mem_rd, 1);
        fetch_en = 0;
        run(2);
        gnt_pct = 100;
        step();
        gnt_pct = 0;
        step();
        check("stop_rd_low", mem_rd, 0);
        check("stop_state_idle", dbg_state, 0);

        // Randomized traffic with random branches.
        br_mode = 4; br_pct = 3; dly_min = 1; dly_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) fetch_en = ($urandom_range(3) != 0);
            gnt_pct = $urandom_range(100, 30);
            pop_pct = $urandom_range(100, 20);
            step();
        end

        // Drain and confirm every expected write was seen.
        br_mode = 0; fetch_en = 0; pop_pct = 100; gnt_pct = 100;
        run(40);
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_mem_empty", mem_q.size(), 0);

        // Asynchronous reset mid-stream.
        fetch_en = 1;
        run(10);
        @(posedge CLK);
        #2 RSTb = 1'b0;
        #1;
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_mem_addr", mem_addr, 16'h0000);
        check("midrst_fifo_wr", fifo_wr, 0);
        check("midrst_fifo_data", fifo_data, 0);
        check("midrst_fifo_flush", fifo_flush, 0);
        check("midrst_state", dbg_state, 0);
        mem_q.delete();
        exp_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
